if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Writer side of the IF/ID pipeline register: the instruction fetch stage.
- Owns the PC and issues requests to instruction memory with a req/ready handshake.
- Drives the IF/ID register's instruction, pc+4 and write-enable inputs.
- Absorbs decode stalls, branch/jump redirects and memory wait states, inserting NOP bubbles where needed.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction width.

Ports:
- clock  in  1  pipeline clock; all state changes on posedge.
- startin  in  1  reset; synchronous, active-high.
- stall  in  1  hazard unit: IF/ID must not be written this cycle.
- redirect  in  1  taken branch/jump resolved downstream; flush and retarget.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address (current PC).
- imem_ready  in  1  imem_rdata valid for the presented request this cycle.
- imem_rdata  in  DATA_W  fetched instruction.
- instruction_out  out  DATA_W  to IF/ID instruction_input.
- pc_plus_4_out  out  ADDR_W  to IF/ID pc_plus_4_input.
- ifid_write  out  1  to IF/ID write.

Behaviour:
- Registered state: pc, state {S_REQ, S_HOLD, S_KILL}, hold_instr, hold_pc4.
- Outputs are combinational from state and inputs.
- Reset (startin=1):
  - Next cycle: pc=RESET_PC, state=S_REQ, hold_instr=0, hold_pc4=0.
  - During the reset cycle: imem_req=0, ifid_write=1, instruction_out=0 (NOP), pc_plus_4_out=0, so IF/ID clears.
  - Reset overrides every other input, including mid-wait and mid-hold.
- Request protocol:
  - imem_req=1 in S_REQ and S_KILL; imem_addr is stable while req=1 and ready=0.
  - A request completes in the cycle imem_ready=1. Zero-wait memory (ready every cycle) gives one instruction per cycle.
- S_REQ, with imem_addr=pc:
  - ready & !stall: ifid_write=1, instruction_out=imem_rdata, pc_plus_4_out=pc+4; pc<=pc+4; stay in S_REQ.
  - ready & stall: ifid_write=0; hold_instr<=imem_rdata, hold_pc4<=pc+4, pc<=pc+4; go to S_HOLD.
  - !ready & !stall: bubble. ifid_write=1, instruction_out=0, pc_plus_4_out=pc.
  - !ready & stall: ifid_write=0.
- S_HOLD:
  - imem_req=0; instruction_out=hold_instr, pc_plus_4_out=hold_pc4.
  - ifid_write=!stall. When !stall, go to S_REQ next cycle.
- S_KILL: a discarded request is still outstanding.
  - imem_addr is the old address (kill_addr register).
  - ifid_write=!stall with NOP; pc_plus_4_out=pc.
  - On ready, the data is dropped and the state goes to S_REQ, which fetches pc.
- Redirect, priority below reset and above everything else:
  - In all states: ifid_write=1, instruction_out=0, pc_plus_4_out=0 (flush overrides stall). pc<={redirect_pc[ADDR_W-1:2],2'b00}.
  - From S_REQ with !ready: kill_addr<=pc, go to S_KILL.
  - From S_REQ with ready: the returned data is discarded, go to S_REQ.
  - From S_HOLD: held instruction discarded, go to S_REQ.
  - From S_KILL: stay in S_KILL; the old request is still drained.
- Arithmetic: pc+4 is modulo 2^ADDR_W. 32'hFFFF_FFFC + 4 = 0, and no flag is raised.
- At most one outstanding request. No instruction is ever delivered twice or skipped except on redirect.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR = 32'h0000_0000 (also used by IF/ID reset).
  - fetch state typedef/encoding.
  - ADDR_W/DATA_W defaults.
- No sub-module; one block with a state register, pc register and hold buffer.

Test Plan:
- Reset then zero-wait memory (ready=1 always, rdata=addr|1): writes {1,4},{5,8},{9,12} on consecutive cycles; pc 0→4→8→12.
- Memory wait: ready low for 2 cycles at pc=8 → two NOP writes with pc_plus_4_out=8, then the instruction at 8 with pc_plus_4_out=12.
- Stall during completion at pc=4 for 3 cycles → ifid_write=0 for 3 cycles, imem_req=0 in S_HOLD. On release, exactly one write of {rdata@4, 8}, then the fetch of 8.
- Redirect to 32'h0000_0103 while stall=1 → same cycle ifid_write=1, instr=0; next fetch address is 32'h100.
- Redirect while request at 0x20 is waiting:
  - imem_addr stays 0x20 until ready; that data is dropped.
  - Then req at the redirect target; no write ever carries rdata@0x20.
- pc=32'hFFFF_FFFC delivers pc_plus_4_out=0 and next fetch at 0. Asserting startin in S_HOLD returns to pc=RESET_PC with an IF/ID NOP write.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID register.
package if_fetch_unit_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 32;
    localparam int unsigned DEFAULT_DATA_W = 32;

    // All-zero word doubles as the bubble the IF/ID register resets to.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        StReq,
        StHold,
        StKill
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, talks req/ready to instruction memory and
// feeds the IF/ID register, absorbing stalls, redirects and memory wait states.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned       DATA_W   = DEFAULT_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              startin,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instruction_out,
    output logic [ADDR_W-1:0] pc_plus_4_out,
    output logic              ifid_write
);

    localparam logic [DATA_W-1:0] Nop = DATA_W'(NOP_INSTR);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;
    logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0] hold_pc4_q, hold_pc4_d;
    logic [ADDR_W-1:0] pc_plus_4;

    assign pc_plus_4 = pc_q + ADDR_W'(4);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        kill_addr_d     = kill_addr_q;
        hold_instr_d    = hold_instr_q;
        hold_pc4_d      = hold_pc4_q;
        imem_req        = 1'b0;
        imem_addr       = pc_q;
        ifid_write      = 1'b0;
        instruction_out = Nop;
        pc_plus_4_out   = pc_q;

        if (startin) begin
            ifid_write    = 1'b1;
            pc_plus_4_out = '0;
            state_d       = StReq;
            pc_d          = RESET_PC;
            kill_addr_d   = '0;
            hold_instr_d  = '0;
            hold_pc4_d    = '0;
        end else begin
            unique case (state_q)
                StReq: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        pc_d = pc_plus_4;
                        if (stall) begin
                            hold_instr_d = imem_rdata;
                            hold_pc4_d   = pc_plus_4;
                            state_d      = StHold;
                        end else begin
                            ifid_write      = 1'b1;
                            instruction_out = imem_rdata;
                            pc_plus_4_out   = pc_plus_4;
                        end
                    end else begin
                        // Memory wait: push a bubble unless decode is holding IF/ID.
                        ifid_write = !stall;
                    end
                end
                StHold: begin
                    instruction_out = hold_instr_q;
                    pc_plus_4_out   = hold_pc4_q;
                    ifid_write      = !stall;
                    if (!stall) state_d = StReq;
                end
                StKill: begin
                    imem_req   = 1'b1;
                    imem_addr  = kill_addr_q;
                    ifid_write = !stall;
                    if (imem_ready) state_d = StReq;
                end
                default: state_d = StReq;
            endcase

            // Flush wins over stall; an orphaned request must still drain in StKill.
            if (redirect) begin
                ifid_write      = 1'b1;
                instruction_out = Nop;
                pc_plus_4_out   = '0;
                pc_d            = {redirect_pc[ADDR_W-1:2], 2'b00};
                unique case (state_q)
                    StReq: begin
                        if (imem_ready) begin
                            state_d = StReq;
                        end else begin
                            kill_addr_d = pc_q;
                            state_d     = StKill;
                        end
                    end
                    StHold:  state_d = StReq;
                    StKill:  state_d = imem_ready ? StReq : StKill;
                    default: state_d = StReq;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        state_q      <= state_d;
        pc_q         <= pc_d;
        kill_addr_q  <= kill_addr_d;
        hold_instr_q <= hold_instr_d;
        hold_pc4_q   <= hold_pc4_d;
    end

endmodule
